// File: rtl/text_typewriter_ctrl_if.sv
// Bundles the buffer write port, the sequence controls and the renderer read port of the typewriter.
interface text_typewriter_ctrl_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] text_len;
    logic       start;
    logic       skip;
    logic       pause;
    logic [7:0] readAddress;
    logic [7:0] outByte;
    logic [4:0] reveal_count;
    logic       busy;
    logic       done;
    logic       char_strobe;

    modport master (
        output wr_en, wr_addr, wr_data, text_len, start, skip, pause, readAddress,
        input  outByte, reveal_count, busy, done, char_strobe
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, text_len, start, skip, pause, readAddress,
        output outByte, reveal_count, busy, done, char_strobe
    );
endinterface

// File: rtl/text_typewriter_ctrl.sv
// Typewriter reveal sequencer for a 16-character text row with a masked, registered read port.
// One reveal every CHAR_DELAY cycles; pause freezes pacing, skip reveals everything at once.
module text_typewriter_ctrl #(
    parameter logic [31:0] CHAR_DELAY     = 32'd50000,
    parameter logic [7:0]  ADDRESS_OFFSET = 8'd0,
    parameter logic [7:0]  BLANK_CHAR     = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    text_typewriter_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, TYPE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [4:0]  len, len_nxt;
    logic [4:0]  rc_nxt;
    logic        strobe_nxt;
    logic [7:0]  mem [16];
    logic [7:0]  idx;
    logic        visible;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        len_nxt    = len;
        rc_nxt     = bus.reveal_count;
        strobe_nxt = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    len_nxt   = (bus.text_len > 5'd16) ? 5'd16 : bus.text_len;
                    rc_nxt    = 5'd0;
                    cnt_nxt   = 32'd0;
                    state_nxt = (len_nxt == 5'd0) ? DONE : TYPE;
                end
            end
            TYPE: begin
                if (bus.skip) begin
                    rc_nxt    = len;
                    state_nxt = DONE;
                end else if (bus.pause) begin
                    cnt_nxt = cnt;
                end else if (cnt == CHAR_DELAY - 32'd1) begin
                    cnt_nxt    = 32'd0;
                    rc_nxt     = bus.reveal_count + 5'd1;
                    strobe_nxt = 1'b1;
                    if (rc_nxt == len)
                        state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done follow the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 32'd0;
            len              <= 5'd0;
            bus.reveal_count <= 5'd0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.char_strobe  <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            len              <= len_nxt;
            bus.reveal_count <= rc_nxt;
            bus.busy         <= (state_nxt == TYPE);
            bus.done         <= (state_nxt == DONE);
            bus.char_strobe  <= strobe_nxt;
        end
    end

    // Buffer is frozen while typing so the visible text cannot change under the renderer.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state != TYPE))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign idx     = bus.readAddress - ADDRESS_OFFSET;
    assign visible = (idx < 8'd16) && (idx < {3'b000, bus.reveal_count});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.outByte <= BLANK_CHAR;
        else
            bus.outByte <= visible ? mem[idx[3:0]] : BLANK_CHAR;
    end

endmodule
